// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared constants, types and state encoding for the frame scheduler
package trace_pkg;

    localparam int COLS    = 128;
    localparam int ROWS    = 64;
    localparam int COL_W   = 7;
    localparam int ROW_W   = 6;
    localparam int COLOR_W = 12;
    localparam int WDOG_W  = 12;
    localparam int TCNT_W  = 8;

    // Colour layout is {b[3:0], g[3:0], r[3:0]}
    typedef logic [COLOR_W-1:0] color_t;

    // Magenta marks blocks the core never answered
    localparam color_t ERR_COLOR = 12'hF0F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_FLIP_WAIT
    } sched_state_t;

endpackage

// File: rtl/trace_scan_counter.sv
// rtl/trace_scan_counter.sv - row-major block column/row counter with clear, advance and last flag
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear             return to block (0,0)
//   advance           step to the next block in row-major order
//   col, row          current block
//   nxt_col, nxt_row  block that advance would step to
//   last              current block is the final block of the frame
module trace_scan_counter
    import trace_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] nxt_col,
    output logic [ROW_W-1:0] nxt_row,
    output logic             last
);

    always_comb begin
        last    = (col == COL_W'(COLS - 1)) && (row == ROW_W'(ROWS - 1));
        nxt_col = col + COL_W'(1);
        nxt_row = row;
        if (col == COL_W'(COLS - 1)) begin
            nxt_col = '0;
            nxt_row = row + ROW_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            col <= nxt_col;
            row <= nxt_row;
        end
    end

endmodule

// File: rtl/trace_frame_scheduler.sv
// rtl/trace_frame_scheduler.sv - walks the tracer core over the block grid into the back frame bank
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   enable                start a new frame (only looked at between frames)
//   vblank                display vertical blanking; bank swap only happens here
//   trc_start             one-cycle request to the core for trc_col/trc_row
//   trc_col, trc_row      block being traced, held until the result or timeout
//   trc_done, trc_color   core result strobe and colour
//   wr_en, wr_col, wr_row, wr_data  frame RAM write into the back bank
//   buf_sel               bank being written; the display reads the other one
//   busy                  scheduler is not idle
//   frame_done            one-cycle pulse on each bank swap
//   timeout_cnt           saturating count of blocks that timed out this frame
module trace_frame_scheduler
    import trace_pkg::*;
#(
    parameter int TIMEOUT = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              vblank,
    output logic              trc_start,
    output logic [COL_W-1:0]  trc_col,
    output logic [ROW_W-1:0]  trc_row,
    input  logic              trc_done,
    input  color_t            trc_color,
    output logic              wr_en,
    output logic [COL_W-1:0]  wr_col,
    output logic [ROW_W-1:0]  wr_row,
    output color_t            wr_data,
    output logic              buf_sel,
    output logic              busy,
    output logic              frame_done,
    output logic [TCNT_W-1:0] timeout_cnt
);

    sched_state_t      state;
    logic [WDOG_W-1:0] watchdog;

    logic             cnt_clear;
    logic             cnt_advance;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] nxt_col;
    logic [ROW_W-1:0] nxt_row;
    logic             cnt_last;

    // The counter always holds the block currently in flight; trc_col/trc_row
    // are loaded from its next value so they are valid in the ISSUE cycle itself.
    always_comb begin
        cnt_clear   = enable && ((state == S_IDLE) || ((state == S_FLIP_WAIT) && vblank));
        cnt_advance = (state == S_WRITE) && !cnt_last;
    end

    trace_scan_counter u_scan (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .advance (cnt_advance),
        .col     (cur_col),
        .row     (cur_row),
        .nxt_col (nxt_col),
        .nxt_row (nxt_row),
        .last    (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            watchdog    <= '0;
            trc_start   <= 1'b0;
            trc_col     <= '0;
            trc_row     <= '0;
            wr_en       <= 1'b0;
            wr_col      <= '0;
            wr_row      <= '0;
            wr_data     <= '0;
            buf_sel     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            trc_start  <= 1'b0;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state       <= S_ISSUE;
                        trc_start   <= 1'b1;
                        trc_col     <= '0;
                        trc_row     <= '0;
                        watchdog    <= '0;
                        timeout_cnt <= '0;
                        busy        <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    state    <= S_WAIT;
                    watchdog <= '0;
                end

                S_WAIT: begin
                    // A result arriving on the timeout cycle still counts as answered
                    if (trc_done) begin
                        state   <= S_WRITE;
                        wr_en   <= 1'b1;
                        wr_col  <= cur_col;
                        wr_row  <= cur_row;
                        wr_data <= trc_color;
                    end else if (watchdog == WDOG_W'(TIMEOUT)) begin
                        state   <= S_WRITE;
                        wr_en   <= 1'b1;
                        wr_col  <= cur_col;
                        wr_row  <= cur_row;
                        wr_data <= ERR_COLOR;
                        if (timeout_cnt != {TCNT_W{1'b1}})
                            timeout_cnt <= timeout_cnt + TCNT_W'(1);
                    end else begin
                        watchdog <= watchdog + WDOG_W'(1);
                    end
                end

                S_WRITE: begin
                    if (cnt_last) begin
                        state <= S_FLIP_WAIT;
                    end else begin
                        state     <= S_ISSUE;
                        trc_start <= 1'b1;
                        trc_col   <= nxt_col;
                        trc_row   <= nxt_row;
                        watchdog  <= '0;
                    end
                end

                S_FLIP_WAIT: begin
                    if (vblank) begin
                        buf_sel    <= ~buf_sel;
                        frame_done <= 1'b1;
                        if (enable) begin
                            state       <= S_ISSUE;
                            trc_start   <= 1'b1;
                            trc_col     <= '0;
                            trc_row     <= '0;
                            watchdog    <= '0;
                            timeout_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
